// File: rtl/seq_right_shifter.sv
// seq_right_shifter -- multi-cycle SRL/SRA unit with start/busy/done handshake, rev 1.0
// Shifts 1 bit per cycle; define SHIFT_RADIX4_EN to shift 4 bits per cycle while >=4 remain.
`default_nettype none

module seq_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

  state_t             state;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   sr_next;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_next;
  logic               fill;

  always_comb begin
    sr_next  = {fill, sr[WIDTH-1:1]};
    cnt_next = cnt - CNT_ONE;
`ifdef SHIFT_RADIX4_EN
    if (cnt >= SHAMT_W'(4)) begin
      sr_next  = {{4{fill}}, sr[WIDTH-1:4]};
      cnt_next = cnt - SHAMT_W'(4);
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sr     <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr   <= operand;
            cnt  <= shamt;
            fill <= arith & operand[WIDTH-1];
            busy <= 1'b1;
            // A zero shift completes immediately with the operand unchanged.
            if (shamt == CNT_ZERO) begin
              result <= operand;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt_next;
          if (cnt_next == CNT_ZERO) begin
            result <= sr_next;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
